driver: RTL and testbench
=========================

DRIVER -- requirements
Module: driver

Interface
REQ-001 Parameter PROG_BYTES, default 16: number of program bytes streamed to the processor.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per serial bit; one bit per processor clock at half rate.
REQ-003 Parameter PROG, default byte i = {i[3:0], ~i[3:0]} (byte0=0x0F, byte1=0x1E, byte15=0xF0): program image with byte 0 in the LSBs.
REQ-004 Parameters MODE_IDLE=2'b00, MODE_LOAD=2'b01, MODE_RUN=2'b10: mode_out encodings.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 drive  input  1  start request; level-sensitive, sampled only in IDLE.
REQ-008 cs  input  1  processor chip-select, active low; frames the serial transfer.
REQ-009 done_in  input  1  processor load-complete flag.
REQ-010 mode_out  output  2  processor mode select.
REQ-011 mosi_out  output  1  serial program data to the processor, MSB first.
REQ-012 done_out  output  1  high once the whole program is delivered and acknowledged.

Function
REQ-013 The block SHALL be an FSM with states IDLE, WAIT_CS, SHIFT, WAIT_DONE and FINISH, with all outputs registered.
REQ-014 IDLE: mode_out=MODE_IDLE, mosi_out=0, done_out=0; drive=1 moves to WAIT_CS and sets mode_out=MODE_LOAD on that edge.
REQ-015 WAIT_CS: mode_out stays MODE_LOAD; cs=0 moves to SHIFT, clears the bit counter and drives mosi_out = bit 7 of the current byte.
REQ-016 SHIFT: each bit is held for exactly CLK_DIV cycles.
REQ-017 SHIFT bit order: the next bit is presented after CLK_DIV cycles, MSB first; after bit 0 the byte index increments and bit 7 of the next byte follows with no gap.
REQ-018 After bit 0 of byte PROG_BYTES-1 has been held CLK_DIV cycles, the FSM moves to WAIT_DONE and mosi_out returns to 0.
REQ-019 cs=1 during SHIFT returns the FSM to WAIT_CS; the bit counter clears and the byte index is kept, so the interrupted byte restarts from bit 7.
REQ-020 WAIT_DONE: mode_out stays MODE_LOAD; done_in=1 moves to FINISH.
REQ-021 FINISH: done_out=1 and mode_out=MODE_RUN, held until reset; drive, cs and done_in are ignored.
REQ-022 done_in=1 before WAIT_DONE is ignored.
REQ-023 Byte index width = clog2(PROG_BYTES), minimum 1 bit; it does not wrap, because the FSM exits at the final byte.
REQ-024 Bit counter width = 3; divider counter width = clog2(CLK_DIV), minimum 1 bit.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, mode_out=MODE_IDLE, mosi_out=0, done_out=0, and clear all counters, including mid-transfer.
REQ-026 After rst_n rises, the first state change occurs on the first clk rising edge where drive=1.

Verification
REQ-027 Reset, drive=0 for 50 cycles -> mode_out=00, mosi_out=0, done_out=0 throughout.
REQ-028 drive=1, then cs=0 -> mode_out=01, and mosi_out shows 0,0,0,0,1,1,1,1 (0x0F), each bit for 2 clk cycles, then 0x1E immediately after.
REQ-029 Full stream of 16 bytes ending 0xF0 (256 clk after cs fall), then done_in=1 -> done_out=1 and mode_out=10 one cycle later, and they stay there.
REQ-030 cs=1 after 3 bits of byte 1, then cs=0 -> byte 1 restarts at its MSB (0x1E sent complete), and byte 0 is not resent.
REQ-031 done_in=1 pulsed during SHIFT -> no effect on the stream; done_out stays 0 until done_in=1 in WAIT_DONE.
REQ-032 rst_n=0 mid-byte 5 -> outputs go to 00/0/0 asynchronously; a new drive=1 restarts the stream at byte 0.

Source files
------------

// File: rtl/driver.sv
// driver: streams a program image MSB-first to a processor under cs framing,
// then waits for its load-complete flag and switches it to run mode.
module driver #(
  parameter int PROG_BYTES = 16,
  parameter int CLK_DIV = 2,
  parameter logic [PROG_BYTES*8-1:0] PROG = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F,
  parameter logic [1:0] MODE_IDLE = 2'b00,
  parameter logic [1:0] MODE_LOAD = 2'b01,
  parameter logic [1:0] MODE_RUN = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive,
  input  logic       cs,
  input  logic       done_in,
  output logic [1:0] mode_out,
  output logic       mosi_out,
  output logic       done_out
);
  localparam int BW = PROG_BYTES > 1 ? $clog2(PROG_BYTES) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_CS, SHIFT, WAIT_DONE, FINISH} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] byte_q, byte_d, byte_nxt;
  logic [2:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] mode_q, mode_d;
  logic mosi_q, mosi_d, done_q, done_d;
  logic [7:0] cur, nxt;
  always_comb begin
    byte_nxt = byte_q + 1'b1;
    cur = PROG[{byte_q, 3'b000} +: 8];
    nxt = PROG[{byte_nxt, 3'b000} +: 8];
    state_d = state_q;
    byte_d = byte_q;
    bit_d = bit_q;
    div_d = div_q;
    mode_d = mode_q;
    mosi_d = mosi_q;
    done_d = done_q;
    case (state_q)
      IDLE: if (drive) begin
        state_d = WAIT_CS;
        mode_d = MODE_LOAD;
      end
      WAIT_CS: if (!cs) begin
        state_d = SHIFT;
        bit_d = 3'd0;
        div_d = '0;
        mosi_d = cur[7];
      end
      SHIFT: if (cs) begin
        // interrupted byte restarts from its MSB; byte index is kept
        state_d = WAIT_CS;
        bit_d = 3'd0;
        div_d = '0;
        mosi_d = 1'b0;
      end else if (div_q != DW'(CLK_DIV - 1)) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        bit_d = bit_q + 3'd1;
        if (bit_q != 3'd7) begin
          mosi_d = cur[3'd6 - bit_q];
        end else if (byte_q == BW'(PROG_BYTES - 1)) begin
          state_d = WAIT_DONE;
          mosi_d = 1'b0;
        end else begin
          byte_d = byte_nxt;
          mosi_d = nxt[7];
        end
      end
      WAIT_DONE: if (done_in) begin
        state_d = FINISH;
        mode_d = MODE_RUN;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q <= '0;
      bit_q <= 3'd0;
      div_q <= '0;
      mode_q <= MODE_IDLE;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      bit_q <= bit_d;
      div_q <= div_d;
      mode_q <= mode_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
    end
  end
  assign mode_out = mode_q;
  assign mosi_out = mosi_q;
  assign done_out = done_q;
endmodule

// File: tb/tb_driver.sv
// tb_driver: stream-position model checked every cycle, plus literal byte/mode checks.
module tb_driver;
  localparam int PB = 16;
  localparam int CD = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drive = 1'b0, cs = 1'b1, done_in = 1'b0;
  logic [1:0] mode_out;
  logic mosi_out, done_out;
  int n_chk = 0, n_fail = 0;
  int ph = 0, base = 0, t = 0;
  logic [15:0] v;

  driver dut (
    .clk(clk), .rst_n(rst_n), .drive(drive), .cs(cs), .done_in(done_in),
    .mode_out(mode_out), .mosi_out(mosi_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  function automatic logic pbit(input int g);
    int b;
    logic [7:0] pb;
    b = g / 8;
    pb = {b[3:0], ~b[3:0]};
    return pb[7 - (g % 8)];
  endfunction

  // ph: 0 idle, 1 awaiting cs, 2 streaming, 3 awaiting done_in, 4 finished
  // streaming shows global bit base*8 + t/CD, t = cycles since stream (re)start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0;
      base <= 0;
      t <= 0;
    end else begin
      case (ph)
        0: if (drive) ph <= 1;
        1: if (!cs) begin ph <= 2; t <= 0; end
        2: if (cs) begin
             ph <= 1;
             base <= (base * 8 + t / CD) / 8;
           end else begin
             t <= t + 1;
             if (base * 8 + (t + 1) / CD >= 8 * PB) ph <= 3;
           end
        3: if (done_in) ph <= 4;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    e = {ph == 0 ? 2'b00 : ph == 4 ? 2'b10 : 2'b01,
         ph == 2 ? pbit(base * 8 + t / CD) : 1'b0,
         ph == 4};
    n_chk++;
    if ({mode_out, mosi_out, done_out} !== e) begin
      n_fail++;
      $display("FAIL model_cycle ph=%0d t=%0d got mode/mosi/done=%b required %b",
               ph, t, {mode_out, mosi_out, done_out}, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic grab16(output logic [15:0] s);
    s = '0;
    repeat (16) begin
      @(negedge clk);
      s = {s[14:0], mosi_out};
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {mode_out, mosi_out, done_out}, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_after_50", {mode_out, mosi_out, done_out}, 0);
    drive = 1'b1;
    @(negedge clk);
    chk("load_mode", mode_out, 2'b01);
    drive = 1'b0;
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    grab16(v);
    chk("byte0", v, 16'h00FF);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("cs_abort", {mode_out, mosi_out, done_out}, 4'b0100);
    cs = 1'b0;
    grab16(v);
    chk("byte1_restart", v, 16'h03FC);
    repeat (13) grab16(v);
    grab16(v);
    chk("byte15", v, 16'hFF00);
    @(negedge clk);
    chk("wait_done", {mode_out, mosi_out, done_out}, 4'b0100);
    done_in = 1'b1;
    @(negedge clk);
    chk("finish", {mode_out, mosi_out, done_out}, 4'b1001);
    done_in = 1'b0;
    drive = 1'b1;
    repeat (10) begin
      cs = ~cs;
      @(negedge clk);
    end
    chk("finish_hold", {mode_out, mosi_out, done_out}, 4'b1001);
    drive = 1'b0;
    cs = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive = 1'b1;
    cs = 1'b0;
    @(negedge clk);
    drive = 1'b0;
    grab16(v);
    chk("run2_byte0", v, 16'h00FF);
    repeat (69) @(negedge clk);
    chk("mid_byte5_mode", mode_out, 2'b01);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {mode_out, mosi_out, done_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive = 1'b1;
    @(negedge clk);
    drive = 1'b0;
    grab16(v);
    chk("restart_byte0", v, 16'h00FF);
    repeat (14) grab16(v);
    grab16(v);
    chk("run3_byte15", v, 16'hFF00);
    @(negedge clk);
    chk("run3_wait_done", {mode_out, mosi_out, done_out}, 4'b0100);
    done_in = 1'b1;
    @(negedge clk);
    chk("run3_finish", {mode_out, mosi_out, done_out}, 4'b1001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
